mux_rr_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one 4:1 mux datapath between four requesters.
- Chooses a winner, drives the mux select and holds it for a burst, terminated by the requester's last flag or by a beat limit.
- Presents the selected stream on a valid/ready output port.
- Sits between four producer streams and one downstream consumer.

---
 rtl/mux_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 30 +++
 rtl/mux_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_BUSY
  } state_e;

  // Decode a requester index into a one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] s);
    logic [N_REQ-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: rotate so last_win+1 sits at bit 0, then
// priority-encode the lowest set bit and rotate the index back.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_win,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0]   start;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   idx;

  // Rotate-then-encode; the 2-bit add wraps modulo 4 naturally.
  always_comb begin
    start = last_win + 2'd1;
    dbl   = {req, req};
    rot   = dbl[start +: N_REQ];
    if (rot[0])      idx = 2'd0;
    else if (rot[1]) idx = 2'd1;
    else if (rot[2]) idx = 2'd2;
    else             idx = 2'd3;
    winner = start + idx;
    any    = |req;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four streams. A winner holds
// the select for a burst ended by its last flag, a beat limit, or a dropped
// request; every grant is followed by one idle cycle.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] din,
  input  logic [N_REQ-1:0]        dlast,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        grant,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEL_W-1:0] last_win_q, last_win_d;

  logic [SEL_W-1:0]  winner;
  logic              any;
  logic              req_sel;
  logic              last_sel;
  logic [DATA_W-1:0] lane;

  rr_pick u_rr_pick (
    .req      (req),
    .last_win (last_win_q),
    .winner   (winner),
    .any      (any)
  );

  // Mux the selected requester's valid, last and data lane.
  always_comb begin
    req_sel  = 1'b0;
    last_sel = 1'b0;
    lane     = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (sel_q == SEL_W'(i)) begin
        req_sel  = req[i];
        last_sel = dlast[i];
        lane     = din[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stream outputs are gated by busy; out_last ignores out_ready.
  always_comb begin
    busy      = (state_q == ST_BUSY);
    out_valid = busy & req_sel;
    out_last  = busy & req_sel & (last_sel | (count_q == LAST_CNT));
    out_data  = busy ? lane : '0;
    grant     = grant_q;
    sel       = sel_q;
  end

  // Next-state logic: grant in IDLE, count beats and release in BUSY.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    count_d    = count_q;
    last_win_d = last_win_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_BUSY;
          sel_d   = winner;
          grant_d = onehot4(winner);
          count_d = '0;
        end
      end
      ST_BUSY: begin
        // A dropped request aborts the burst; a final transfer ends it.
        if (!req_sel || (out_ready && out_last)) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          count_d    = '0;
          last_win_d = sel_q;
        end else if (out_ready) begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; pointer resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      grant_q    <= '0;
      count_q    <= '0;
      last_win_q <= 2'd3;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      count_q    <= count_d;
      last_win_q <= last_win_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (DATA_W = 1, MAX_BURST = 4).
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] dlast;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       out_valid;
  logic [0:0] out_data;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(
    .DATA_W    (1),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .dlast     (dlast),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; din = '0; dlast = '0; out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111; din = '0; dlast = '0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 ||
        out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got grant=%b sel=%0d busy=%b valid=%b last=%b want 0000/0/0/0/0",
               grant, sel, busy, out_valid, out_last);
    end
    tick();
    req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0100; din = 4'b0100; dlast = 4'b0000; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pre: got grant=%b busy=%b want 0000/0", grant, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || sel !== 2'd2 || out_valid !== 1'b1 ||
        out_data !== 1'b1 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL single_beat1: got grant=%b sel=%0d valid=%b data=%b last=%b want 0100/2/1/1/0",
               grant, sel, out_valid, out_data, out_last);
    end
    tick();
    dlast = 4'b0100;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || out_valid !== 1'b1 || out_data !== 1'b1 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL single_beat2: got grant=%b valid=%b data=%b last=%b want 0100/1/1/1",
               grant, out_valid, out_data, out_last);
    end
    tick();
    req = '0; dlast = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got grant=%b busy=%b valid=%b want 0000/0/0",
               grant, busy, out_valid);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111; dlast = 4'b1111; din = 4'b1010; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp = 4'b0001 << (k % 4);
      @(negedge clk);
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL fair_gap%0d: got grant=%b busy=%b want 0000/0", k, grant, busy);
      end
      tick();
      @(negedge clk);
      checks++;
      if (grant !== exp || sel !== 2'(k % 4) || out_last !== 1'b1 ||
          out_data !== din[k % 4]) begin
        errors++;
        $display("FAIL fair_grant%0d: got grant=%b sel=%0d last=%b data=%b want %b/%0d/1/%b",
                 k, grant, sel, out_last, out_data, exp, k % 4, din[k % 4]);
      end
      tick();
    end
    req = '0; dlast = '0;
  endtask

  task automatic test_burst_limit();
    req = 4'b0001; dlast = 4'b0000; out_ready = 1'b1;
    @(negedge clk);
    tick();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0001 || out_valid !== 1'b1 || out_last !== (b == 3)) begin
        errors++;
        $display("FAIL burst_beat%0d: got grant=%b valid=%b last=%b want 0001/1/%b",
                 b, grant, out_valid, out_last, (b == 3));
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_release: got grant=%b busy=%b want 0000/0", grant, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL burst_regrant: got grant=%b busy=%b want 0001/1", grant, busy);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    int xfers;
    xfers = 0;
    req = 4'b0010; dlast = 4'b0000; out_ready = 1'b1;
    tick();
    // Beat 1 transfers.
    @(negedge clk);
    if (out_valid && out_ready) xfers++;
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0010 || out_valid !== 1'b1 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: got grant=%b valid=%b last=%b want 0010/1/0",
                 s, grant, out_valid, out_last);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_last !== (b == 3)) begin
        errors++;
        $display("FAIL bp_beat%0d: got valid=%b last=%b want 1/%b", b, out_valid, out_last, (b == 3));
      end
      if (out_valid && out_ready) xfers++;
      tick();
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (xfers != 4 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL bp_total: got xfers=%0d grant=%b want 4/0000", xfers, grant);
    end
  endtask

  task automatic test_abort();
    req = 4'b1000; dlast = 4'b0000; out_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b1000 || sel !== 2'd3) begin
      errors++;
      $display("FAIL abort_grant: got grant=%b sel=%0d want 1000/3", grant, sel);
    end
    tick();
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL abort_valid: got valid=%b last=%b want 0/0", out_valid, out_last);
    end
    tick();
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: got grant=%b busy=%b want 0000/0", grant, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL abort_next: got grant=%b want 0001", grant);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b0100; dlast = 4'b0000; out_ready = 1'b1;
    tick();
    tick();
    #2;
    checks++;
    if (busy !== 1'b1 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL areset_pre: got busy=%b grant=%b want 1/0100", busy, grant);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL areset_now: got grant=%b busy=%b valid=%b sel=%0d want 0000/0/0/0",
               grant, busy, out_valid, sel);
    end
    req = 4'b1111;
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL areset_first: got grant=%b want 0001", grant);
    end
    req = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_burst_limit();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
